// File: rtl/turn_timer_defs.sv
// turn_timer_defs: shared FSM state and player encodings for the turn timer
package turn_timer_defs;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_EXPIRE = 2'd3
  } state_t;
  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: enable/clear counter that pulses o_wrap on its last count
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DIV_BITS = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);
  logic [DIV_BITS-1:0] r_cnt;
  logic w_last;
  assign w_last = r_cnt == DIV_BITS'(TICK_DIV - 1);
  assign o_wrap = i_en && w_last;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= w_last ? '0 : r_cnt + DIV_BITS'(1);
endmodule

// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: per-player turn countdown with pause, reload on move and timeout forfeit
module turn_timer_ctrl
  import turn_timer_defs::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DIV_BITS  = 27,
  parameter int TURN_SECS = 15,
  parameter int SEC_BITS  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                move_done,
  input  logic                pause,
  output logic [SEC_BITS-1:0] secs_left,
  output logic                player,
  output logic                active,
  output logic                sec_tick,
  output logic                timeout
);
  localparam logic [SEC_BITS-1:0] RELOAD = SEC_BITS'(TURN_SECS);
  state_t              r_state, w_state_nxt;
  logic [SEC_BITS-1:0] r_secs, w_secs_nxt;
  logic                r_player, w_player_nxt;
  logic                r_tick, w_tick_nxt;
  logic                r_timeout, r_active;
  logic                w_wrap, w_clr;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .DIV_BITS(DIV_BITS)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == ST_RUN),
    .i_clr (w_clr),
    .o_wrap(w_wrap)
  );
  always_comb begin
    w_state_nxt  = r_state;
    w_secs_nxt   = r_secs;
    w_player_nxt = r_player;
    w_clr        = 1'b0;
    w_tick_nxt   = 1'b0;
    if (stop && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_secs_nxt  = RELOAD;
      w_clr       = 1'b1;
    end else
      case (r_state)
        ST_IDLE:
          if (start) begin
            w_state_nxt = ST_RUN;
            w_secs_nxt  = RELOAD;
            w_clr       = 1'b1;
          end
        ST_RUN:
          if (move_done) begin
            w_player_nxt = ~r_player;
            w_secs_nxt   = RELOAD;
            w_clr        = 1'b1;
          end else if (w_wrap) begin
            // expiry is judged on the pre-decrement value so secs_left cannot underflow
            w_secs_nxt  = r_secs - SEC_BITS'(1);
            w_tick_nxt  = 1'b1;
            w_state_nxt = (r_secs == SEC_BITS'(1)) ? ST_EXPIRE : pause ? ST_HOLD : ST_RUN;
          end else if (pause) w_state_nxt = ST_HOLD;
        ST_HOLD: w_state_nxt = pause ? ST_HOLD : ST_RUN;
        ST_EXPIRE: begin
          w_state_nxt  = ST_RUN;
          w_player_nxt = ~r_player;
          w_secs_nxt   = RELOAD;
          w_clr        = 1'b1;
        end
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= ST_IDLE;
      r_secs    <= RELOAD;
      r_player  <= PLAYER_X;
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_secs    <= w_secs_nxt;
      r_player  <= w_player_nxt;
      r_tick    <= w_tick_nxt;
      r_timeout <= w_state_nxt == ST_EXPIRE;
      r_active  <= w_state_nxt == ST_RUN || w_state_nxt == ST_HOLD;
    end
  assign secs_left = r_secs;
  assign player    = r_player;
  assign active    = r_active;
  assign sec_tick  = r_tick;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_turn_timer_ctrl.sv
// tb_turn_timer_ctrl: directed and random checks of turn_timer_ctrl against a behavioural model
module tb_turn_timer_ctrl;
  localparam int TD = 4;
  localparam int TS = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_EXP = 3;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, move_done = 1'b0, pause = 1'b0;
  logic [2:0] secs_left;
  logic player, active, sec_tick, timeout;
  int npass = 0, ntot = 0;
  int m_mode = M_IDLE, m_cnt = 0, m_secs = TS, m_player = 0, m_tick = 0, m_to = 0;
  logic p = 1'b0;

  turn_timer_ctrl #(.TICK_DIV(TD), .DIV_BITS(3), .TURN_SECS(TS), .SEC_BITS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .move_done(move_done),
    .pause    (pause),
    .secs_left(secs_left),
    .player   (player),
    .active   (active),
    .sec_tick (sec_tick),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // m_cnt counts elapsed clocks inside the current second of running time
  task automatic model_step();
    m_tick = 0;
    m_to   = 0;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_secs = TS; m_player = 0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin m_mode = M_RUN; m_cnt = 0; m_secs = TS; end
    end else if (stop) begin
      m_mode = M_IDLE; m_cnt = 0; m_secs = TS;
    end else if (m_mode == M_EXP) begin
      m_mode = M_RUN; m_player = 1 - m_player; m_secs = TS; m_cnt = 0;
    end else if (m_mode == M_HOLD) begin
      if (!pause) m_mode = M_RUN;
    end else if (move_done) begin
      m_player = 1 - m_player; m_secs = TS; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == TD) begin m_cnt = 0; m_secs--; m_tick = 1; end
      if (m_secs == 0) begin m_mode = M_EXP; m_to = 1; end
      else if (pause) m_mode = M_HOLD;
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic sp, input logic mv, input logic pa);
    rst = r; start = st; stop = sp; move_done = mv; pause = pa;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("secs_left", secs_left, m_secs);
    chk("player", player, m_player);
    chk("active", active, (m_mode == M_RUN || m_mode == M_HOLD));
    chk("sec_tick", sec_tick, m_tick);
    chk("timeout", timeout, m_to);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    chk("rst_secs", secs_left, 3);
    chk("rst_player", player, 0);
    chk("rst_active", active, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      chk("exp_tick", sec_tick, (k == 5 || k == 9 || k == 13));
      chk("exp_timeout", timeout, k == 13);
      chk("exp_secs", secs_left, TS - (k - 1) / 4);
      cyc(0, 0, 0, 0, 0);
    end
    chk("exp_next_player", player, 1);
    chk("exp_next_secs", secs_left, 3);
    chk("exp_next_active", active, 1);
    cyc(0, 0, 1, 0, 0);
    chk("stop_player", player, 1);
    chk("stop_active", active, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    chk("mv_secs_before", secs_left, 2);
    cyc(0, 0, 0, 1, 0);
    chk("mv_player", player, 0);
    chk("mv_secs", secs_left, 3);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("mv_tick_early", sec_tick, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mv_tick", sec_tick, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("pause_secs", secs_left, 3);
      chk("pause_tick", sec_tick, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("resume_tick_early", sec_tick, 0);
    cyc(0, 0, 0, 0, 0);
    chk("resume_tick", sec_tick, 1);
    chk("resume_secs", secs_left, 2);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (11) cyc(0, 0, 0, 0, 0);
    chk("race_secs_before", secs_left, 1);
    cyc(0, 0, 0, 1, 0);
    chk("race_timeout", timeout, 0);
    chk("race_tick", sec_tick, 0);
    chk("race_player", player, 1);
    chk("race_secs", secs_left, 3);
    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("start_ignored_secs", secs_left, 3);
    chk("start_ignored_player", player, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("stop_mid_active", active, 0);
    chk("stop_mid_player", player, 1);
    chk("stop_mid_secs", secs_left, 3);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_mid_secs", secs_left, 3);
    chk("rst_mid_player", player, 0);
    chk("rst_mid_active", active, 0);
    repeat (4000) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 11) == 0, p);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
